// File: rtl/enc_snapshot_sched_pkg.sv
// rtl/enc_snapshot_sched_pkg.sv - shared state encoding and width defaults for the encoder snapshot scheduler
// Purpose: state encoding plus channel-count and counter-width defaults that are
//          shared with the encoder counter bank and the SPI register map.
// Ports:   none (package).
package enc_sched_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] STREAM  = 2'd2;

  localparam int ENC_CNT_W = 16;
  localparam int ENC_NUM   = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_CAPTURE = CAPTURE,
    ST_STREAM  = STREAM
  } st_e;

endpackage

// File: rtl/enc_snapshot_sched_if.sv
// rtl/enc_snapshot_sched_if.sv - delta word stream from the snapshot scheduler to the SPI transmit path
// Purpose: groups the valid/ready output stream of enc_snapshot_sched.
// Signals: out_valid, out_ready, out_data (signed delta or timestamp),
//          out_idx (word index), out_last (final word of the frame).
// Modports: master = scheduler side, slave = SPI readout side.
interface enc_snapshot_sched_if #(
  parameter int CNT_W = 16,
  parameter int IDX_W = 3
) ();

  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;

  modport master (
    output out_valid, out_data, out_idx, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_idx, out_last,
    output out_ready
  );

endinterface

// File: rtl/enc_period_timer.sv
// rtl/enc_period_timer.sv - programmable countdown that pulses once per snapshot period
// Purpose: counts period_cfg clocks and pulses expire_o for one cycle when the
//          count reaches 1, then reloads. Held in reload while enable is low or
//          period_cfg is zero.
// Ports:   clk, rst_n (async active-low), enable, period_cfg[PER_W], expire_o.
module enc_period_timer #(
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [PER_W-1:0] period_cfg,
  output logic             expire_o
);

  logic [PER_W-1:0] timer_q, timer_d;

  always_comb begin
    timer_d  = timer_q;
    expire_o = 1'b0;
    if (!enable || period_cfg == '0) begin
      timer_d = period_cfg;
    end else if (timer_q == PER_W'(1)) begin
      expire_o = 1'b1;
      timer_d  = period_cfg;
    end else if (timer_q == '0) begin
      // Only reachable straight out of reset with enable already high:
      // start a fresh period rather than firing immediately.
      timer_d = period_cfg;
    end else begin
      timer_d = timer_q - PER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_q <= '0;
    else        timer_q <= timer_d;
  end

endmodule

// File: rtl/enc_snapshot_sched.sv
// rtl/enc_snapshot_sched.sv - periodic/on-demand encoder snapshot with per-channel delta streaming
// Purpose: latches all encoder counts on one edge (timer expiry or sample_req),
//          computes modulo-2^CNT_W deltas against the previous snapshot and
//          streams them one word per channel over a valid/ready handshake.
// Ports:   clk, rst_n (async active-low), enc_count[NUM_ENC*CNT_W], enable,
//          period_cfg[PER_W], sample_req, ovr_clr, overrun (sticky dropped
//          trigger), out (enc_snapshot_sched_if.master delta stream).
// Config:  ENC_SNAPSHOT_TIMESTAMP_EN appends a free-running clock-count word
//          at idx NUM_ENC and moves out_last onto it.
module enc_snapshot_sched
  import enc_sched_pkg::*;
#(
  parameter int NUM_ENC = ENC_NUM,
  parameter int CNT_W   = ENC_CNT_W,
  parameter int PER_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_ENC*CNT_W-1:0] enc_count,
  input  logic                     enable,
  input  logic [PER_W-1:0]         period_cfg,
  input  logic                     sample_req,
  input  logic                     ovr_clr,
  output logic                     overrun,
  enc_snapshot_sched_if.master     out
);

  localparam int IDX_W = $clog2(NUM_ENC + 1);
`ifdef ENC_SNAPSHOT_TIMESTAMP_EN
  localparam int NUM_WORDS = NUM_ENC + 1;
`else
  localparam int NUM_WORDS = NUM_ENC;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  st_e              state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             primed_q;
  logic             overrun_q;
  logic [CNT_W-1:0] prev_q  [NUM_ENC];
  logic [CNT_W-1:0] delta_q [NUM_ENC];
  logic [CNT_W-1:0] word;
  logic             tmr_expire, trig, hs, final_hs, ovr_set;

  enc_period_timer #(.PER_W(PER_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .period_cfg (period_cfg),
    .expire_o   (tmr_expire)
  );

  assign trig     = sample_req | tmr_expire;
  assign hs       = (state_q == ST_STREAM) & out.out_ready;
  assign final_hs = hs & (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ovr_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (trig) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = ST_STREAM;
        idx_d   = '0;
        ovr_set = trig;
      end
      ST_STREAM: begin
        if (final_hs) begin
          // A trigger coinciding with the last handshake starts the next
          // frame directly instead of counting as an overrun.
          idx_d   = '0;
          state_d = trig ? ST_CAPTURE : ST_IDLE;
        end else begin
          ovr_set = trig;
          if (hs) idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      primed_q  <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_ENC; i++) begin
        prev_q[i]  <= '0;
        delta_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= ovr_set | (overrun_q & ~ovr_clr);
      if (state_q == ST_CAPTURE) begin
        primed_q <= 1'b1;
        for (int i = 0; i < NUM_ENC; i++) begin
          prev_q[i]  <= enc_count[i*CNT_W +: CNT_W];
          // Unsigned subtraction wraps, which is exactly the signed delta
          // across a counter rollover.
          delta_q[i] <= primed_q ? (enc_count[i*CNT_W +: CNT_W] - prev_q[i]) : '0;
        end
      end
    end
  end

`ifdef ENC_SNAPSHOT_TIMESTAMP_EN
  logic [CNT_W-1:0] ts_cnt_q, ts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + CNT_W'(1);
      if (state_q == ST_CAPTURE) ts_q <= ts_cnt_q;
    end
  end
`endif

  // Compare-based mux keeps the timestamp slot out of the delta array range.
  always_comb begin
    word = '0;
    for (int i = 0; i < NUM_ENC; i++) begin
      if (idx_q == IDX_W'(i)) word = delta_q[i];
    end
`ifdef ENC_SNAPSHOT_TIMESTAMP_EN
    if (idx_q == IDX_W'(NUM_ENC)) word = ts_q;
`endif
  end

  assign out.out_valid = (state_q == ST_STREAM);
  assign out.out_data  = out.out_valid ? word : '0;
  assign out.out_idx   = idx_q;
  assign out.out_last  = out.out_valid & (idx_q == LAST_IDX);
  assign overrun       = overrun_q;

endmodule
